// File: rtl/pll_lock_supervisor_if.sv
// PLL-facing and system-facing signals of the lock supervisor.
// The master side is the supervisor; the slave side is the PLL plus system glue.
interface pll_lock_supervisor_if #(
  parameter int CNT_W = 8
);
  logic             pll_locked;
  logic             clear_fault;
  logic             pll_rst;
  logic             sys_rst_out;
  logic             ready;
  logic             fault;
  logic [CNT_W-1:0] relock_count;

  modport master (
    input  pll_locked, clear_fault,
    output pll_rst, sys_rst_out, ready, fault, relock_count
  );
  modport slave (
    output pll_locked, clear_fault,
    input  pll_rst, sys_rst_out, ready, fault, relock_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses pll_rst, waits for and qualifies lock, then releases
// the system reset. It runs on refclk only, so it never depends on PLL output clocks.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int RETRY_LIMIT         = 3,
  parameter int CNT_W               = 8
) (
  input  logic                          refclk,
  input  logic                          rst,
  pll_lock_supervisor_if.master         pif
);
  localparam int MAX_A   = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam int RW      = $clog2(RETRY_LIMIT + 1);

  typedef enum logic [2:0] {
    S_PLL_RST, S_WAIT_LOCK, S_STABLE, S_RUN, S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [RW-1:0]    retry_q;
  logic [CNT_W-1:0] relock_q;
  logic [1:0]       sync_q;
  logic             locked_s;
  logic             timeout;

  assign locked_s = sync_q[1];

  // pll_locked is asynchronous to refclk; nothing but locked_s may look at it.
  always_ff @(posedge refclk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], pif.pll_locked};
  end

  always_ff @(posedge refclk) begin
    if (rst) state_q <= S_PLL_RST;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      S_PLL_RST:
        if (cnt_q == CW'(RST_PULSE_CYCLES - 1)) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK:
        if (locked_s) state_d = S_STABLE;
        else if (cnt_q == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          // retry_q is about to become retry_q+1; fault once that reaches the limit
          state_d = (retry_q == RW'(RETRY_LIMIT - 1)) ? S_FAULT : S_PLL_RST;
        end
      S_STABLE:
        if (!locked_s) state_d = S_WAIT_LOCK;
        else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) state_d = S_RUN;
      S_RUN:
        if (!locked_s) state_d = S_PLL_RST;
      S_FAULT:
        if (pif.clear_fault) state_d = S_PLL_RST;
      default:
        state_d = S_PLL_RST;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      cnt_q    <= '0;
      retry_q  <= '0;
      relock_q <= '0;
    end else begin
      cnt_q <= (state_d != state_q) ? '0 : cnt_q + CW'(1);
      if (timeout)
        retry_q <= retry_q + RW'(1);
      else if ((state_q == S_STABLE && state_d == S_RUN) ||
               (state_q == S_FAULT  && state_d == S_PLL_RST))
        retry_q <= '0;
      if (state_q == S_RUN && state_d == S_PLL_RST && relock_q != '1)
        relock_q <= relock_q + CNT_W'(1);
    end
  end

  // Outputs come straight off the state register so they cannot glitch.
  always_comb begin
    pif.pll_rst      = (state_q == S_PLL_RST) || (state_q == S_FAULT);
    pif.sys_rst_out  = (state_q != S_RUN);
    pif.ready        = (state_q == S_RUN);
    pif.fault        = (state_q == S_FAULT);
    pif.relock_count = relock_q;
  end
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: vector table, directed corner sequences and random
// lock/clear/reset stimulus, all checked against a timestamp-based reference model.
module tb_pll_lock_supervisor;
  localparam int P = 4, S = 8, T = 32, R = 2, CW = 2;
  localparam int RLK_MAX = (1 << CW) - 1;

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  pll_lock_supervisor_if #(.CNT_W(CW)) pif();

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES(P), .LOCK_STABLE_CYCLES(S), .LOCK_TIMEOUT_CYCLES(T),
    .RETRY_LIMIT(R), .CNT_W(CW)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .pif   (pif)
  );

  always #10 refclk = ~refclk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phases end at absolute edge deadlines; lock is seen two edges late.
  typedef enum int {PH_PULSE, PH_WAIT, PH_QUAL, PH_RUN, PH_FAULT} ph_t;
  ph_t         ph = PH_PULSE;
  int unsigned now_e = 0, t_mark = 0;
  int          tries = 0, relocks = 0;
  bit          m_valid = 1'b0;
  bit          lk_q[$];

  always @(posedge refclk) begin
    bit lk;
    now_e++;
    if (rst) begin
      m_valid = 1'b1;
      ph      = PH_PULSE;
      t_mark  = now_e + P;
      tries   = 0;
      relocks = 0;
      lk_q    = '{1'b0, 1'b0};
    end else if (m_valid) begin
      lk = lk_q.pop_front();
      lk_q.push_back(pif.pll_locked);
      case (ph)
        PH_PULSE: if (now_e == t_mark) begin ph = PH_WAIT; t_mark = now_e + T; end
        PH_WAIT:
          if (lk) begin ph = PH_QUAL; t_mark = now_e + S; end
          else if (now_e == t_mark) begin
            tries++;
            if (tries == R) ph = PH_FAULT;
            else begin ph = PH_PULSE; t_mark = now_e + P; end
          end
        PH_QUAL:
          if (!lk) begin ph = PH_WAIT; t_mark = now_e + T; end
          else if (now_e == t_mark) begin ph = PH_RUN; tries = 0; end
        PH_RUN:
          if (!lk) begin
            ph = PH_PULSE; t_mark = now_e + P;
            if (relocks < RLK_MAX) relocks++;
          end
        PH_FAULT:
          if (pif.clear_fault) begin ph = PH_PULSE; t_mark = now_e + P; tries = 0; end
        default: ;
      endcase
    end
  end

  always @(negedge refclk) begin
    if (m_valid) begin
      chk("model_pll_rst", int'(pif.pll_rst), int'(ph == PH_PULSE || ph == PH_FAULT));
      chk("model_sys_rst", int'(pif.sys_rst_out), int'(ph != PH_RUN));
      chk("model_ready",   int'(pif.ready), int'(ph == PH_RUN));
      chk("model_fault",   int'(pif.fault), int'(ph == PH_FAULT));
      chk("model_relock",  int'(pif.relock_count), relocks);
    end
  end

  // Advance n edges with inputs held, checking fixed expected outputs after each edge.
  task automatic seg(input string name, input bit prst, input bit srst,
                     input bit rdy, input bit flt, input int n);
    repeat (n) begin
      @(negedge refclk);
      chk({name, ".pll_rst"}, int'(pif.pll_rst), int'(prst));
      chk({name, ".sys_rst"}, int'(pif.sys_rst_out), int'(srst));
      chk({name, ".ready"},   int'(pif.ready), int'(rdy));
      chk({name, ".fault"},   int'(pif.fault), int'(flt));
    end
  endtask

  typedef struct {
    bit rst, lk, cf;
    int n;
    bit prst, srst, rdy, flt;
    int rlk;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int lat;
    bit got;
    pif.pll_locked  = 1'b0;
    pif.clear_fault = 1'b0;

    // 1. nominal lock: lock rises 10 cycles after reset release
    tbl[0] = '{1, 0, 0,  2, 1, 1, 0, 0, 0};
    tbl[1] = '{0, 0, 0,  3, 1, 1, 0, 0, 0};
    tbl[2] = '{0, 0, 1,  7, 0, 1, 0, 0, 0};
    tbl[3] = '{0, 1, 0, 10, 0, 1, 0, 0, 0};
    tbl[4] = '{0, 1, 0,  5, 0, 0, 1, 0, 0};
    tbl[5] = '{0, 1, 1,  2, 0, 0, 1, 0, 0};
    @(negedge refclk);
    for (int i = 0; i < 6; i++) begin
      rst = tbl[i].rst; pif.pll_locked = tbl[i].lk; pif.clear_fault = tbl[i].cf;
      seg($sformatf("t1_row%0d", i), tbl[i].prst, tbl[i].srst, tbl[i].rdy, tbl[i].flt, tbl[i].n);
      chk($sformatf("t1_row%0d.relock", i), int'(pif.relock_count), tbl[i].rlk);
    end
    pif.clear_fault = 1'b0;

    // 2. lock chatter during qualification
    rst = 1'b1; pif.pll_locked = 1'b0;
    seg("t2_rst", 1, 1, 0, 0, 1);
    rst = 1'b0;
    seg("t2_pulse", 1, 1, 0, 0, 3);
    seg("t2_wait", 0, 1, 0, 0, 2);
    pif.pll_locked = 1'b1; seg("t2_hi5", 0, 1, 0, 0, 5);
    pif.pll_locked = 1'b0; seg("t2_lo3", 0, 1, 0, 0, 3);
    pif.pll_locked = 1'b1;
    lat = 0; got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge refclk);
      if (pif.ready) begin got = 1'b1; lat = k; end
      else chk("t2_no_pulse", int'(pif.pll_rst), 0);
    end
    chk("t2_ready_seen", int'(got), 1);
    chk("t2_latency", lat, 11);
    chk("t2_sys_rst", int'(pif.sys_rst_out), 0);
    chk("t2_relock", int'(pif.relock_count), 0);

    // 4. lock loss in RUN, four times; relock_count saturates at 3
    for (int i = 0; i < 4; i++) begin
      pif.pll_locked = 1'b0;
      seg("t4_still_run", 0, 0, 1, 0, 2);
      seg("t4_drop", 1, 1, 0, 0, 1);
      pif.pll_locked = 1'b1;
      seg("t4_pulse", 1, 1, 0, 0, 3);
      seg("t4_qual", 0, 1, 0, 0, 9);
      seg("t4_run", 0, 0, 1, 0, 1);
      chk($sformatf("t4_relock%0d", i), int'(pif.relock_count), (i + 1 > RLK_MAX) ? RLK_MAX : i + 1);
    end

    // 3. timeout twice into FAULT, then recovery via clear_fault
    pif.pll_locked = 1'b0;
    seg("t3_run", 0, 0, 1, 0, 2);
    seg("t3_p1", 1, 1, 0, 0, 4);
    seg("t3_w1", 0, 1, 0, 0, 32);
    seg("t3_p2", 1, 1, 0, 0, 4);
    seg("t3_w2", 0, 1, 0, 0, 32);
    seg("t3_fault", 1, 1, 0, 1, 5);
    chk("t3_relock_kept", int'(pif.relock_count), 3);
    pif.pll_locked = 1'b1;
    seg("t3_hold", 1, 1, 0, 1, 4);
    pif.clear_fault = 1'b1;
    seg("t3_clr", 1, 1, 0, 0, 1);
    pif.clear_fault = 1'b0;
    seg("t3_pulse", 1, 1, 0, 0, 3);
    seg("t3_qual", 0, 1, 0, 0, 9);
    seg("t3_ready", 0, 0, 1, 0, 3);
    chk("t3_relock_after", int'(pif.relock_count), 3);

    // 5. reset priority in STABLE (with one retry used) and in FAULT
    rst = 1'b1; pif.pll_locked = 1'b0;
    seg("t5_rst_run", 1, 1, 0, 0, 1);
    chk("t5_relock_clr", int'(pif.relock_count), 0);
    rst = 1'b0;
    seg("t5_p1", 1, 1, 0, 0, 3);
    seg("t5_w1", 0, 1, 0, 0, 32);
    seg("t5_p2a", 1, 1, 0, 0, 1);
    pif.pll_locked = 1'b1;
    seg("t5_p2b", 1, 1, 0, 0, 3);
    seg("t5_stable", 0, 1, 0, 0, 4);
    rst = 1'b1; pif.clear_fault = 1'b1;
    seg("t5_rst_stable", 1, 1, 0, 0, 1);
    rst = 1'b0; pif.clear_fault = 1'b0; pif.pll_locked = 1'b0;
    seg("t5_r1p", 1, 1, 0, 0, 3);
    seg("t5_r1w", 0, 1, 0, 0, 32);
    seg("t5_r2p", 1, 1, 0, 0, 4);
    seg("t5_r2w", 0, 1, 0, 0, 32);
    seg("t5_fault", 1, 1, 0, 1, 3);
    rst = 1'b1; pif.clear_fault = 1'b1;
    seg("t5_rst_fault", 1, 1, 0, 0, 1);
    chk("t5_relock_f", int'(pif.relock_count), 0);
    rst = 1'b0; pif.clear_fault = 1'b0;
    seg("t5_s1p", 1, 1, 0, 0, 3);
    seg("t5_s1w", 0, 1, 0, 0, 32);
    seg("t5_s2p", 1, 1, 0, 0, 4);
    seg("t5_s2w", 0, 1, 0, 0, 32);
    seg("t5_fault2", 1, 1, 0, 1, 2);

    // random segments of lock level, sparse clear_fault and rst; the model checks every edge
    for (int i = 0; i < 3000; ) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 100) : $urandom_range(1, 20);
      pif.pll_locked = 1'($urandom_range(0, 1));
      repeat (len) begin
        pif.clear_fault = ($urandom_range(0, 15) == 0);
        rst = ($urandom_range(0, 299) == 0);
        @(negedge refclk);
        i++;
      end
    end
    rst = 1'b0; pif.clear_fault = 1'b0;
    @(negedge refclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Drives the reset input of a system PLL instance and consumes its lock output.
- Sequences the PLL reset pulse, waits for lock, qualifies lock stability, then releases a downstream system reset.
- On loss of lock, re-resets the PLL; after repeated lock timeouts, parks in a fault state.
- Runs on the free-running 50 MHz board reference clock, which is also the PLL's refclk, so it never depends on PLL output clocks.

Parameters:
- RST_PULSE_CYCLES, 16, width of each pll_rst pulse in refclk cycles (>=1).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before release (>=1).
- LOCK_TIMEOUT_CYCLES, 65536, maximum wait for lock after a pll_rst pulse (>=2).
- RETRY_LIMIT, 3, consecutive lock timeouts before fault (>=1).
- CNT_W, 8, width of relock_count.

Ports:
- refclk, input, 1, free-running reference clock; all logic on its rising edge.
- rst, input, 1, synchronous active-high reset.
- pll_locked, input, 1, PLL lock indicator; asynchronous to refclk.
- clear_fault, input, 1, single-cycle request to leave FAULT.
- pll_rst, output, 1, reset to the PLL.
- sys_rst_out, output, 1, active-high system reset for PLL-clocked logic.
- ready, output, 1, high only in RUN.
- fault, output, 1, high only in FAULT.
- relock_count, output, CNT_W, count of lock losses seen in RUN; saturating.

Behaviour:
- Synchronizer:
  - pll_locked passes through a 2-flop synchronizer to produce locked_s.
  - Only locked_s is used internally.
  - Latency is 2 edges.
- Reset:
  - rst has priority over every other event.
  - On the edge where rst is sampled high: state=PLL_RST, cycle counter=0, retry=0, relock_count=0, and both sync flops=0.
  - Resulting outputs: pll_rst=1, sys_rst_out=1, ready=0, fault=0.
  - rst asserted mid-sequence aborts immediately, from any state including RUN and FAULT.
- Outputs: decoded only from the state register, with no other input paths, so they are glitch-free.
  - pll_rst=1 in PLL_RST and FAULT.
  - sys_rst_out=0 only in RUN.
  - ready=(state==RUN).
  - fault=(state==FAULT).
- Cycle counter:
  - Width is $clog2 of the largest cycle parameter, plus 1.
  - Cleared on every state change.
- States:
  - PLL_RST: stay exactly RST_PULSE_CYCLES cycles, then go to WAIT_LOCK.
  - WAIT_LOCK:
    - locked_s=1: go to STABLE.
    - Otherwise count. On the LOCK_TIMEOUT_CYCLES-th cycle without lock, retry+=1.
    - If the new retry equals RETRY_LIMIT, go to FAULT; else go to PLL_RST.
  - STABLE:
    - locked_s=0: go to WAIT_LOCK. The timeout window restarts and retry is unchanged.
    - After LOCK_STABLE_CYCLES consecutive cycles of locked_s=1: go to RUN and clear retry.
  - RUN:
    - locked_s=0: go to PLL_RST and increment relock_count, saturating at 2^CNT_W-1.
    - sys_rst_out reasserts no later than 3 refclk edges after pll_locked falls.
  - FAULT:
    - Hold until clear_fault=1 is sampled, then go to PLL_RST with retry=0.
    - relock_count is preserved.
- clear_fault is ignored outside FAULT.
- Lock pulses or glitches shorter than one refclk period may be missed; this is acceptable.
- Minimum time from rst release to ready=1 is RST_PULSE_CYCLES + 1 + LOCK_STABLE_CYCLES edges, with lock already present and synchronized.

Test Plan:
All tests use RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, RETRY_LIMIT=2, CNT_W=2.
1. Nominal lock:
   - Stimulus: rst for 2 cycles; pll_locked rises 10 cycles after rst release.
   - Required: pll_rst high for exactly 4 cycles after release; ready rises 2+1+8 edges after the pll_locked rise.
   - Required: sys_rst_out falls on the same edge as ready rises; fault=0 throughout.
2. Lock chatter:
   - Stimulus: pll_locked high for 5 cycles, low for 3, then high continuously.
   - Required: ready stays 0 until 8 uninterrupted locked_s cycles have elapsed; no new pll_rst pulse; relock_count=0.
3. Timeout and fault:
   - Stimulus: pll_locked held 0.
   - Required: two pll_rst pulses of 4 cycles, each followed by a 32-cycle wait; then fault=1 with pll_rst=1 held.
   - Stimulus: assert pll_locked, then pulse clear_fault.
   - Required: fresh 4-cycle pulse, then ready after qualification.
4. Lock loss in RUN:
   - Stimulus: from RUN, drop pll_locked 4 times, each followed by relock.
   - Required: sys_rst_out reasserts within 3 edges of each drop; a 4-cycle pll_rst pulse per drop; relock_count goes 1, 2, 3, 3 (saturates).
5. Reset priority:
   - Stimulus: assert rst in STABLE and in FAULT, with clear_fault also high.
   - Required: next state is PLL_RST; relock_count=0; fault=0; retry cleared.
   - Required: a subsequent timeout needs 2 full retries before fault.
